ysyx_22041412_axi_master: RTL and testbench
===========================================

# ysyx_22041412_axi_master

AXI4 master bridge that sits directly downstream of the IF/MEM AXI arbiter. It converts the arbiter's simple request/beat interface into full AXI4 read (AR/R) and write (AW/W/B) channel handshakes toward the SoC crossbar. The read and write paths are independent state machines, so one read and one write may be in flight at the same time.

## Interface
- AXI_DATA_WIDTH, 64, data bus width
- AXI_ADDR_WIDTH, 32, address width
- AXI_ID_WIDTH, 4, ID width; all IDs driven 0
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, strobe width
- AXI_USER_WIDTH, 1, user width; driven 0

Ports. Reset is rst, synchronous, active-high; clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r_valid_i  in  1  read request; held by requester for whole burst
- r_addr_i  in  AXI_ADDR_WIDTH  read address
- r_size_i / r_len_i  in  3 / 8  arsize / arlen
- r_ready_o  out  1  read beat valid (one pulse per delivered beat)
- data_read_o  out  AXI_DATA_WIDTH  read beat data
- r_last_i  out  1  final read beat, coincident with r_ready_o
- w_valid_i  in  1  write request; held until w_last_i
- w_addr_i  in  AXI_ADDR_WIDTH  write address
- w_size_i / w_len_i  in  3 / 8  awsize / awlen
- rw_w_data_i  in  AXI_DATA_WIDTH  write beat data, lane-aligned by requester
- w_ready_o  out  1  write beat accepted; requester presents next beat next cycle
- w_last_i  out  1  write burst complete (B received), one-cycle pulse
- resp_err_o  out  1  one-cycle pulse on any rresp/bresp != OKAY
- AXI4 master ports, prefix axi_: aw{valid,ready,addr,id,len,size,burst,lock,cache,prot,qos,user}, w{valid,ready,data,strb,last,user}, b{valid,ready,resp,id,user}, ar{…same as aw}, r{valid,ready,data,resp,last,id,user}. Burst = INCR (2'b01); lock, cache, prot, qos = 0.

## Operation
- Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: r_valid_i=1 latches addr/size/len and moves to R_ADDR.
  - R_ADDR: arvalid=1 from latched fields; on arready moves to R_DATA.
  - R_DATA: rready=1; every rvalid beat gives r_ready_o=1 and data_read_o=rdata (combinational pass-through); on rlast, r_last_i=1 and back to R_IDLE.
- Read cancel: if r_valid_i drops while in R_ADDR/R_DATA, set a cancel flag. The AXI transaction still completes (AR held until accepted, all R beats drained). r_ready_o and r_last_i are suppressed until R_IDLE; the flag clears there.
- Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: w_valid_i latches addr/size/len and clears the beat counter.
  - W_ADDR: awvalid until awready.
  - W_DATA: wvalid=1, wdata=rw_w_data_i; wlast = (beat_cnt == len). On wready: w_ready_o=1, beat_cnt+1; the last beat moves to W_RESP.
  - W_RESP: bready=1; on bvalid, w_last_i=1 and back to W_IDLE.
- wstrb: for len==0, mask = (1<<(1<<size))-1 shifted left by addr[2:0], truncated to 8 bits; for len>0, all ones.
- beat_cnt is 8 bits and never wraps (it is bounded by len ≤ 255).
- resp_err_o pulses on an rresp≠0 beat or a bresp≠0. The transfer completes normally either way.

## Timing
- Reset: all axi_*valid, rready, bready, r_ready_o, r_last_i, w_ready_o, w_last_i and resp_err_o are 0. Both FSMs go to IDLE; counters and latches are 0. Reset mid-burst abandons the transaction immediately.
- arvalid/awvalid rise the cycle after the request is sampled in IDLE. Minimum read latency from request to first beat is 2 cycles plus slave latency.
- Valids never drop before their ready. Addr/len/size stay stable while valid is high.
- Back-to-back: after r_last_i or w_last_i the FSM spends ≥1 cycle in IDLE. A request still high in that IDLE cycle starts a new transaction.
- Simultaneous read and write requests proceed concurrently with no ordering between them.
- A W beat does not start before the AW handshake completes.

## Test plan
- Single read: r_valid_i, addr 0x8000_0000, len 0, size 3; slave arready after 2 cycles, rdata 0x1122334455667788 with rlast -> one r_ready_o+r_last_i pulse carrying that data, then R_IDLE.
- 4-beat read burst, len 3, rvalid gapped 1 cycle between beats -> exactly 4 r_ready_o pulses, r_last_i only on the 4th, rready high throughout R_DATA.
- Byte write: addr 0x8000_0005, size 0, len 0 -> wstrb 0x20, wlast=1; bvalid 3 cycles later -> w_last_i pulses once.
- 8-beat write burst, wready toggling -> 8 w_ready_o pulses, wlast on beat 8 only, wstrb 0xFF.
- Cancel: drop r_valid_i after the AR handshake of a len 3 read -> all 4 R beats drained with rready=1, no r_ready_o/r_last_i; a new request is accepted afterwards.
- Concurrent read+write issued the same cycle, plus bresp=SLVERR -> both complete, resp_err_o pulses once; rst asserted mid-burst -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ysyx_22041412_axi_master_if.sv
// AXI4 bus between the master bridge and the SoC crossbar.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on a
// rising clk edge where valid and ready are both 1. The source raises valid
// without waiting for ready. It keeps valid and all payload fields stable until
// that edge. The sink may raise or lower ready at any time.
interface ysyx_22041412_axi_master_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_USER_WIDTH = 1
);
  // write address channel
  logic                      awvalid;
  logic                      awready;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic [AXI_USER_WIDTH-1:0] awuser;
  // write data channel
  logic                      wvalid;
  logic                      wready;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [AXI_STRB_WIDTH-1:0] wstrb;
  logic                      wlast;
  logic [AXI_USER_WIDTH-1:0] wuser;
  // write response channel
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [AXI_USER_WIDTH-1:0] buser;
  // read address channel
  logic                      arvalid;
  logic                      arready;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arqos;
  logic [AXI_USER_WIDTH-1:0] aruser;
  // read data channel
  logic                      rvalid;
  logic                      rready;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_USER_WIDTH-1:0] ruser;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wuser,
    input  wready,
    input  bvalid, bresp, bid, buser,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid, ruser,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wuser,
    output wready,
    output bvalid, bresp, bid, buser,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
    output arready,
    output rvalid, rdata, rresp, rlast, rid, ruser,
    input  rready
  );
endinterface

// File: rtl/ysyx_22041412_axi_master.sv
// AXI4 master bridge: turns the arbiter's request/beat interface into AXI4
// read and write handshakes. Read and write FSMs are independent, so one read
// and one write can be outstanding at the same time.
module ysyx_22041412_axi_master #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // read requester side
  input  logic                      r_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
  input  logic [2:0]                r_size_i,
  input  logic [7:0]                r_len_i,
  output logic                      r_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] data_read_o,
  output logic                      r_last_i,
  // write requester side
  input  logic                      w_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
  input  logic [2:0]                w_size_i,
  input  logic [7:0]                w_len_i,
  input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
  output logic                      w_ready_o,
  output logic                      w_last_i,
  output logic                      resp_err_o,
  // FSM state, exported for debug and checkers
  output logic [1:0]                r_state_o,
  output logic [1:0]                w_state_o,
  ysyx_22041412_axi_master_if.master axi
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam int OFF_W = $clog2(AXI_STRB_WIDTH);

  // read path state
  logic [1:0]                r_state_q, r_state_d;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [2:0]                r_size_q, r_size_d;
  logic [7:0]                r_len_q, r_len_d;
  logic                      r_cancel_q, r_cancel_d;

  // write path state
  logic [1:0]                w_state_q, w_state_d;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [2:0]                w_size_q, w_size_d;
  logic [7:0]                w_len_q, w_len_d;
  logic [7:0]                w_beat_q, w_beat_d;

  logic                      r_beat;
  logic [AXI_STRB_WIDTH-1:0] strb_base;
  logic [AXI_STRB_WIDTH-1:0] strb_single;

  // Read FSM next state: latch the request in IDLE and remember an abandoned request
  always_comb begin
    r_state_d  = r_state_q;
    r_addr_d   = r_addr_q;
    r_size_d   = r_size_q;
    r_len_d    = r_len_q;
    r_cancel_d = r_cancel_q;
    case (r_state_q)
      R_IDLE: begin
        r_cancel_d = 1'b0;
        if (r_valid_i) begin
          r_addr_d  = r_addr_i;
          r_size_d  = r_size_i;
          r_len_d   = r_len_i;
          r_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (!r_valid_i) r_cancel_d = 1'b1;
        if (axi.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (!r_valid_i) r_cancel_d = 1'b1;
        if (axi.rvalid && axi.rlast) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM next state: address first, then beats counted against len, then response
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_size_d  = w_size_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_valid_i) begin
          w_addr_d  = w_addr_i;
          w_size_d  = w_size_i;
          w_len_d   = w_len_i;
          w_beat_d  = 8'd0;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (axi.awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        if (axi.wready) begin
          // The counter stops at len so a 256-beat burst cannot wrap it.
          if (w_beat_q == w_len_q) w_state_d = W_RESP;
          else                     w_beat_d  = w_beat_q + 8'd1;
        end
      end
      W_RESP: begin
        if (axi.bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Single-beat strobe: (1 << size) bytes starting at the address byte offset
  always_comb begin
    strb_base = '0;
    for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
      strb_base[i] = (i < (1 << w_size_q));
    end
    strb_single = strb_base << w_addr_q[OFF_W-1:0];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      r_addr_q   <= '0;
      r_size_q   <= '0;
      r_len_q    <= '0;
      r_cancel_q <= 1'b0;
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_size_q   <= '0;
      w_len_q    <= '0;
      w_beat_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      r_addr_q   <= r_addr_d;
      r_size_q   <= r_size_d;
      r_len_q    <= r_len_d;
      r_cancel_q <= r_cancel_d;
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_size_q   <= w_size_d;
      w_len_q    <= w_len_d;
      w_beat_q   <= w_beat_d;
    end
  end

  // AR / R channel drive; beats are hidden from the requester once it has walked away
  assign axi.arvalid = (r_state_q == R_ADDR);
  assign axi.araddr  = r_addr_q;
  assign axi.arid    = '0;
  assign axi.arlen   = r_len_q;
  assign axi.arsize  = r_size_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arqos   = 4'd0;
  assign axi.aruser  = '0;
  assign axi.rready  = (r_state_q == R_DATA);

  assign r_beat      = axi.rready && axi.rvalid;
  assign r_ready_o   = r_beat && !r_cancel_q && r_valid_i;
  assign r_last_i    = r_ready_o && axi.rlast;
  assign data_read_o = axi.rdata;

  // AW / W / B channel drive
  assign axi.awvalid = (w_state_q == W_ADDR);
  assign axi.awaddr  = w_addr_q;
  assign axi.awid    = '0;
  assign axi.awlen   = w_len_q;
  assign axi.awsize  = w_size_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awqos   = 4'd0;
  assign axi.awuser  = '0;
  assign axi.wvalid  = (w_state_q == W_DATA);
  assign axi.wdata   = rw_w_data_i;
  assign axi.wstrb   = (w_len_q == 8'd0) ? strb_single : '1;
  assign axi.wlast   = (w_beat_q == w_len_q);
  assign axi.wuser   = '0;
  assign axi.bready  = (w_state_q == W_RESP);

  assign w_ready_o   = axi.wvalid && axi.wready;
  assign w_last_i    = axi.bready && axi.bvalid;

  // Any non-OKAY response on an accepted R beat or B response
  assign resp_err_o  = (r_beat && (axi.rresp != 2'b00)) ||
                       (w_last_i && (axi.bresp != 2'b00));

  assign r_state_o   = r_state_q;
  assign w_state_o   = w_state_q;

endmodule

// File: tb/tb_ysyx_22041412_axi_master.sv
// Directed testbench for ysyx_22041412_axi_master. The bench acts as both the
// requester and the AXI slave. A negedge monitor counts requester-side pulses.
module tb_ysyx_22041412_axi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r_valid_i = 1'b0;
  logic [31:0] r_addr_i = '0;
  logic [2:0]  r_size_i = '0;
  logic [7:0]  r_len_i = '0;
  logic        r_ready_o;
  logic [63:0] data_read_o;
  logic        r_last_i;
  logic        w_valid_i = 1'b0;
  logic [31:0] w_addr_i = '0;
  logic [2:0]  w_size_i = '0;
  logic [7:0]  w_len_i = '0;
  logic [63:0] rw_w_data_i = '0;
  logic        w_ready_o;
  logic        w_last_i;
  logic        resp_err_o;
  logic [1:0]  r_state_o;
  logic [1:0]  w_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  ysyx_22041412_axi_master_if axi_bus ();

  ysyx_22041412_axi_master dut (
    .clk         (clk),
    .rst         (rst),
    .r_valid_i   (r_valid_i),
    .r_addr_i    (r_addr_i),
    .r_size_i    (r_size_i),
    .r_len_i     (r_len_i),
    .r_ready_o   (r_ready_o),
    .data_read_o (data_read_o),
    .r_last_i    (r_last_i),
    .w_valid_i   (w_valid_i),
    .w_addr_i    (w_addr_i),
    .w_size_i    (w_size_i),
    .w_len_i     (w_len_i),
    .rw_w_data_i (rw_w_data_i),
    .w_ready_o   (w_ready_o),
    .w_last_i    (w_last_i),
    .resp_err_o  (resp_err_o),
    .r_state_o   (r_state_o),
    .w_state_o   (w_state_o),
    .axi         (axi_bus.master)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // checking task
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: counters only ever written here
  int          mon_rbeats = 0, mon_rlasts = 0, mon_rlast_at = 0, mon_rhs = 0;
  int          mon_whs = 0, mon_wlast_cnt = 0, mon_wlast_at = 0;
  int          mon_wbeats = 0, mon_wlasts = 0, mon_errs = 0, mon_rready_gap = 0;
  logic [63:0] mon_rdata = '0;
  logic [7:0]  mon_wstrb = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (r_ready_o) begin
        mon_rbeats++;
        mon_rdata = data_read_o;
      end
      if (r_last_i) begin
        mon_rlasts++;
        mon_rlast_at = mon_rbeats;
      end
      if (axi_bus.rvalid && axi_bus.rready) mon_rhs++;
      if (axi_bus.wvalid && axi_bus.wready) begin
        mon_whs++;
        mon_wstrb = axi_bus.wstrb;
        if (axi_bus.wlast) begin
          mon_wlast_cnt++;
          mon_wlast_at = mon_whs;
        end
      end
      if (w_ready_o)  mon_wbeats++;
      if (w_last_i)   mon_wlasts++;
      if (resp_err_o) mon_errs++;
      if (r_state_o == 2'd2 && !axi_bus.rready) mon_rready_gap++;
    end
  end

  // snapshot of monitor counters at test start
  int s_rbeats, s_rlasts, s_rhs, s_whs, s_wlast_cnt, s_wbeats, s_wlasts, s_errs, s_gap;

  task automatic snap();
    s_rbeats    = mon_rbeats;
    s_rlasts    = mon_rlasts;
    s_rhs       = mon_rhs;
    s_whs       = mon_whs;
    s_wlast_cnt = mon_wlast_cnt;
    s_wbeats    = mon_wbeats;
    s_wlasts    = mon_wlasts;
    s_errs      = mon_errs;
    s_gap       = mon_rready_gap;
  endtask

  // driver: read slave, also drops r_valid_i like the requester would
  task automatic rd_slave(input int ar_dly, input int nbeats, input int gap,
                          input logic [63:0] d0, input logic [1:0] resp, input bit drop_after_ar);
    int w;
    w = 0;
    while (!axi_bus.arvalid && w < 50) begin
      tick();
      w++;
    end
    check("ar_seen", axi_bus.arvalid, 1);
    repeat (ar_dly) tick();
    axi_bus.arready = 1'b1;
    #1;
    check("araddr", axi_bus.araddr, r_addr_i);
    check("arlen", axi_bus.arlen, r_len_i);
    tick();
    axi_bus.arready = 1'b0;
    if (drop_after_ar) r_valid_i = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          axi_bus.rvalid = 1'b0;
          tick();
        end
      end
      axi_bus.rvalid = 1'b1;
      axi_bus.rdata  = d0 + 64'(i);
      axi_bus.rresp  = resp;
      axi_bus.rlast  = (i == nbeats - 1);
      tick();
    end
    axi_bus.rvalid = 1'b0;
    axi_bus.rlast  = 1'b0;
    axi_bus.rresp  = 2'b00;
    r_valid_i      = 1'b0;
  endtask

  // driver: write slave, also drops w_valid_i after the response
  task automatic wr_slave(input int aw_dly, input int nbeats, input bit toggle,
                          input int b_dly, input logic [1:0] resp);
    int w, acc, cyc;
    w = 0;
    while (!axi_bus.awvalid && w < 50) begin
      tick();
      w++;
    end
    check("aw_seen", axi_bus.awvalid, 1);
    repeat (aw_dly) tick();
    axi_bus.awready = 1'b1;
    #1;
    check("awaddr", axi_bus.awaddr, w_addr_i);
    check("wvalid_before_aw", axi_bus.wvalid, 0);
    tick();
    axi_bus.awready = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < nbeats && cyc < 200) begin
      axi_bus.wready = toggle ? cyc[0] : 1'b1;
      #1;
      if (axi_bus.wvalid && axi_bus.wready) begin
        if (acc == 0) check("wdata", axi_bus.wdata, rw_w_data_i);
        acc++;
      end
      tick();
      cyc++;
    end
    axi_bus.wready = 1'b0;
    check("w_beats_accepted", acc, nbeats);
    repeat (b_dly) tick();
    axi_bus.bvalid = 1'b1;
    axi_bus.bresp  = resp;
    #1;
    check("bready", axi_bus.bready, 1);
    tick();
    axi_bus.bvalid = 1'b0;
    axi_bus.bresp  = 2'b00;
    w_valid_i      = 1'b0;
  endtask

  initial begin
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    axi_bus.bvalid  = 1'b0;
    axi_bus.bresp   = 2'b00;
    axi_bus.bid     = '0;
    axi_bus.buser   = '0;
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b0;
    axi_bus.rdata   = '0;
    axi_bus.rresp   = 2'b00;
    axi_bus.rlast   = 1'b0;
    axi_bus.rid     = '0;
    axi_bus.ruser   = '0;

    // reset state
    repeat (3) tick();
    check("rst_arvalid", axi_bus.arvalid, 0);
    check("rst_awvalid", axi_bus.awvalid, 0);
    check("rst_wvalid", axi_bus.wvalid, 0);
    check("rst_rready", axi_bus.rready, 0);
    check("rst_bready", axi_bus.bready, 0);
    check("rst_r_state", r_state_o, 0);
    check("rst_w_state", w_state_o, 0);
    rst = 1'b0;
    tick();

    // single read
    snap();
    r_addr_i = 32'h8000_0000; r_size_i = 3'd3; r_len_i = 8'd0;
    r_valid_i = 1'b1;
    #1;
    check("single_arvalid_not_yet", axi_bus.arvalid, 0);
    rd_slave(2, 1, 0, 64'h1122_3344_5566_7788, 2'b00, 1'b0);
    tick();
    check("single_rbeats", mon_rbeats - s_rbeats, 1);
    check("single_rlasts", mon_rlasts - s_rlasts, 1);
    check("single_rdata", mon_rdata, 64'h1122_3344_5566_7788);
    check("single_idle", r_state_o, 0);

    // 4-beat burst, 1-cycle gaps
    snap();
    r_addr_i = 32'h8000_0100; r_size_i = 3'd3; r_len_i = 8'd3;
    r_valid_i = 1'b1;
    rd_slave(0, 4, 1, 64'hA000_0000_0000_0000, 2'b00, 1'b0);
    tick();
    check("burst_rbeats", mon_rbeats - s_rbeats, 4);
    check("burst_rlasts", mon_rlasts - s_rlasts, 1);
    check("burst_rlast_on_4th", mon_rlast_at - s_rbeats, 4);
    check("burst_rdata_last", mon_rdata, 64'hA000_0000_0000_0003);
    check("burst_rready_gap", mon_rready_gap - s_gap, 0);

    // byte write
    snap();
    w_addr_i = 32'h8000_0005; w_size_i = 3'd0; w_len_i = 8'd0;
    rw_w_data_i = 64'h0000_AB00_0000_0000;
    w_valid_i = 1'b1;
    #1;
    check("byte_awvalid_not_yet", axi_bus.awvalid, 0);
    wr_slave(1, 1, 1'b0, 3, 2'b00);
    tick();
    check("byte_wstrb", mon_wstrb, 8'h20);
    check("byte_wlast_beat", mon_wlast_at - s_whs, 1);
    check("byte_w_ready", mon_wbeats - s_wbeats, 1);
    check("byte_w_last", mon_wlasts - s_wlasts, 1);

    // 8-beat write burst, wready toggling
    snap();
    w_addr_i = 32'h8000_1000; w_size_i = 3'd3; w_len_i = 8'd7;
    rw_w_data_i = 64'hDEAD_BEEF_0123_4567;
    w_valid_i = 1'b1;
    wr_slave(0, 8, 1'b1, 1, 2'b00);
    tick();
    check("wburst_w_ready", mon_wbeats - s_wbeats, 8);
    check("wburst_wlast_cnt", mon_wlast_cnt - s_wlast_cnt, 1);
    check("wburst_wlast_on_8th", mon_wlast_at - s_whs, 8);
    check("wburst_wstrb", mon_wstrb, 8'hFF);
    check("wburst_w_last", mon_wlasts - s_wlasts, 1);

    // read cancel after AR handshake
    snap();
    r_addr_i = 32'h8000_0200; r_size_i = 3'd3; r_len_i = 8'd3;
    r_valid_i = 1'b1;
    rd_slave(0, 4, 0, 64'h5555_0000_0000_0000, 2'b00, 1'b1);
    tick();
    check("cancel_drained", mon_rhs - s_rhs, 4);
    check("cancel_rbeats", mon_rbeats - s_rbeats, 0);
    check("cancel_rlasts", mon_rlasts - s_rlasts, 0);
    check("cancel_idle", r_state_o, 0);
    snap();
    r_addr_i = 32'h8000_0300; r_len_i = 8'd0;
    r_valid_i = 1'b1;
    rd_slave(0, 1, 0, 64'h0BAD_F00D_0000_0001, 2'b00, 1'b0);
    tick();
    check("after_cancel_rbeats", mon_rbeats - s_rbeats, 1);
    check("after_cancel_rdata", mon_rdata, 64'h0BAD_F00D_0000_0001);

    // concurrent read + write, write gets SLVERR
    snap();
    r_addr_i = 32'h8000_0400; r_size_i = 3'd3; r_len_i = 8'd1;
    w_addr_i = 32'h8000_0500; w_size_i = 3'd3; w_len_i = 8'd1;
    rw_w_data_i = 64'h1234_5678_9ABC_DEF0;
    r_valid_i = 1'b1;
    w_valid_i = 1'b1;
    fork
      rd_slave(1, 2, 1, 64'hC0DE_0000_0000_0000, 2'b00, 1'b0);
      wr_slave(0, 2, 1'b0, 2, 2'b10);
    join
    tick();
    check("conc_rlasts", mon_rlasts - s_rlasts, 1);
    check("conc_rbeats", mon_rbeats - s_rbeats, 2);
    check("conc_wlasts", mon_wlasts - s_wlasts, 1);
    check("conc_resp_err", mon_errs - s_errs, 1);

    // reset mid-burst
    r_addr_i = 32'h8000_0600; r_len_i = 8'd3;
    w_addr_i = 32'h8000_0700; w_len_i = 8'd3;
    r_valid_i = 1'b1;
    w_valid_i = 1'b1;
    axi_bus.arready = 1'b1;
    axi_bus.awready = 1'b1;
    axi_bus.rvalid  = 1'b1;
    axi_bus.rresp   = 2'b10;
    axi_bus.wready  = 1'b1;
    repeat (3) tick();
    check("mid_r_in_data", r_state_o, 2);
    rst = 1'b1;
    tick();
    check("mrst_arvalid", axi_bus.arvalid, 0);
    check("mrst_awvalid", axi_bus.awvalid, 0);
    check("mrst_wvalid", axi_bus.wvalid, 0);
    check("mrst_rready", axi_bus.rready, 0);
    check("mrst_bready", axi_bus.bready, 0);
    check("mrst_r_ready_o", r_ready_o, 0);
    check("mrst_r_last_i", r_last_i, 0);
    check("mrst_w_ready_o", w_ready_o, 0);
    check("mrst_w_last_i", w_last_i, 0);
    check("mrst_resp_err", resp_err_o, 0);
    check("mrst_states", {r_state_o, w_state_o}, 0);
    r_valid_i = 1'b0;
    w_valid_i = 1'b0;
    axi_bus.arready = 1'b0;
    axi_bus.awready = 1'b0;
    axi_bus.rvalid  = 1'b0;
    axi_bus.rresp   = 2'b00;
    axi_bus.wready  = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
